// File: rtl/rep_add_mult_seq.sv
// rtl/rep_add_mult_seq.sv - sequential multiplier using repeated addition
//
// Purpose: multiplies a_in by b_in by adding the multiplicand into product
// once per clock while the multiplier counts down to zero. With SWAP_EN=1 the
// larger operand becomes the multiplicand, so the loop runs min(a,b) times.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, highest priority
//   start    request a new multiply (accepted in IDLE or DONE)
//   abort    cancel a running multiply (honoured in RUN only)
//   a_in     multiplicand, captured on accepted start
//   b_in     multiplier, captured on accepted start
//   busy     high while in RUN
//   done     high while in DONE; product valid
//   product  accumulated product, 2*WIDTH bits
//   iter_cnt additions performed in the current/last operation

module rep_add_mult_seq #(
  parameter int WIDTH   = 8,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     iter_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             accept;
  logic             swap;

  // Ties do not swap: strict less-than.
  assign swap = SWAP_EN && (a_in < b_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // busy/done depend only on the registered state, never on inputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (b_reg == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath. The zero test on b_reg comes before the decrement, so b_reg
  // never wraps; the product width holds (2^W-1)^2 without overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      product  <= '0;
      iter_cnt <= '0;
    end else if (accept) begin
      a_reg    <= swap ? b_in : a_in;
      b_reg    <= swap ? a_in : b_in;
      product  <= '0;
      iter_cnt <= '0;
    end else if (state == RUN) begin
      if (abort) begin
        product  <= '0;
        iter_cnt <= '0;
      end else if (b_reg != '0) begin
        product  <= product + {{WIDTH{1'b0}}, a_reg};
        b_reg    <= b_reg - 1'b1;
        iter_cnt <= iter_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/rep_add_mult_seq.md
Name: rep_add_mult_seq

Overview:
Parametrised sequential multiplier using repeated addition; it replaces the fixed-width controller/datapath pair with one self-contained block.
- Adds the following over the previous generation:
  - WIDTH-generic operands and a 2*WIDTH product.
  - Optional operand swap, so the loop runs on the smaller operand.
  - Zero-operand early exit.
  - Abort input and busy output.
  - Back-to-back restart from DONE.
- Sits between a host that issues start pulses and downstream logic that samples product on done.

Parameters:
WIDTH, 8, operand width in bits (>=2)
SWAP_EN, 1, 1 = iterate on the smaller operand; 0 = always iterate on b_in

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request a new multiply; sampled only in IDLE or DONE
abort  in  1  cancel a running multiply; sampled only in RUN
a_in  in  WIDTH  multiplicand, captured on accepted start
b_in  in  WIDTH  multiplier, captured on accepted start
busy  out  1  high while in RUN
done  out  1  high while in DONE; product valid
product  out  2*WIDTH  accumulated product
iter_cnt  out  WIDTH  additions performed in the current/last operation

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset is synchronous, active-high (rst), and has priority over all other inputs.
  - Reset values: state=IDLE, busy=0, done=0, product=0, iter_cnt=0, internal A=0, B=0.
- State machine, 3 states: IDLE, RUN, DONE.
  - busy is 1 only in RUN. done is 1 only in DONE. Both are decoded from the registered state, so they are glitch-free.
- IDLE or DONE with start=1 (accepted start):
  - Captures operands:
    - If SWAP_EN=1 and a_in<b_in: A<=b_in, B<=a_in.
    - Otherwise: A<=a_in, B<=b_in.
  - Clears product and iter_cnt to 0.
  - Next state is RUN.
  - IDLE or DONE with start=0: hold. product and iter_cnt stay stable in DONE.
- RUN: priority order is abort, then B==0, then iterate.
  - abort=1: next state IDLE; product and iter_cnt cleared to 0.
  - B==0: next state DONE; no addition this cycle.
  - Otherwise: product<=product+A (zero-extended to 2*WIDTH), B<=B-1, iter_cnt<=iter_cnt+1.
  - start is ignored while in RUN.
- Latency:
  - Start accepted at edge t; RUN occupies cycles t+1 .. t+1+Bcap.
  - done is first high at cycle t+2+Bcap, where Bcap is the captured B.
  - Zero operand: with SWAP_EN=1, either operand being 0 gives done at t+2 with product=0. With SWAP_EN=0, b_in=0 gives done at t+2.
- Width rules:
  - 2*WIDTH product cannot overflow: max (2^W-1)^2 < 2^(2W). No wrap is possible.
  - B decrement never underflows, because B==0 is checked first.
  - iter_cnt <= 2^W-1, so it fits in WIDTH bits.
- Restart from DONE:
  - start in DONE is accepted exactly as in IDLE.
  - done drops the cycle after acceptance; busy rises in the same cycle.
- abort outside RUN has no effect.
- rst mid-RUN: next cycle shows the IDLE/reset values; no done pulse is produced.
- Swap tie (a_in==b_in): no swap.

Test Plan:
1. WIDTH=8, SWAP_EN=1, a=5, b=3, start at edge 0 -> busy cycles 1-4; done=1 from cycle 5; product=15; iter_cnt=3.
2. a=3, b=200 with SWAP_EN=1 -> done at cycle 5, product=600, iter_cnt=3. Same operands with SWAP_EN=0 -> done at cycle 202, product=600, iter_cnt=200.
3. a=7, b=0 -> done at cycle 2, product=0, iter_cnt=0. a=0, b=9 with SWAP_EN=1 -> done at cycle 2, product=0. Same with SWAP_EN=0 -> done at cycle 11, product=0, iter_cnt=9.
4. a=255, b=255 -> done at cycle 257, product=16'hFE01, iter_cnt=255. Check there is no truncation.
5. Abort, ignored start, reset mid-run:
   - a=10, b=50; start pulse at cycle 3 ignored; abort at cycle 4 -> IDLE at cycle 5, product=0, no done.
   - Repeat with rst at cycle 4 -> all outputs at reset values from cycle 5.
6. Back-to-back: after (6×4) reaches DONE with product=24, start with a=2, b=2 in the same DONE cycle -> done low next cycle, busy high; done again 4 cycles after acceptance with product=4.
